// File: rtl/approx_dot_accumulator.sv
// approx_dot_accumulator
// Sums LEN consecutive 16-bit products from an approximate multiplier and
// hands the dot-product result downstream over a valid/ready handshake.
// While a result is held for the consumer, input is stalled.
module approx_dot_accumulator #(
  parameter int LEN   = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic               out_valid_q, out_valid_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  // One extra bit on the adder captures the carry out of bit ACC_W-1.
  logic [ACC_W:0]     sum_s;
  logic               in_beat_s;
  logic               out_beat_s;

  assign sum_s      = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, in_z};
  assign in_beat_s  = in_valid && in_ready_q;
  assign out_beat_s = out_valid_q && out_ready;

  // Next-state logic: accumulate in ACCUM, hold result in HOLD, clr aborts everything.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_acc_d   = out_acc_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    if (clr) begin
      // Abort: drop the partial sum, any pending result and any beat this cycle.
      state_d     = ACCUM;
      acc_d       = {ACC_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_beat_s) begin
            ovf_d = ovf_q | sum_s[ACC_W];
            if (cnt_q == CNT_LAST) begin
              out_acc_d   = sum_s[ACC_W-1:0];
              out_valid_d = 1'b1;
              acc_d       = {ACC_W{1'b0}};
              cnt_d       = {CNT_W{1'b0}};
              state_d     = HOLD;
            end else begin
              acc_d = sum_s[ACC_W-1:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            // Bubble: nothing changes.
            acc_d = acc_q;
          end
        end
        HOLD: begin
          if (out_beat_s) begin
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
            state_d     = ACCUM;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          state_d     = ACCUM;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          out_valid_d = 1'b0;
          ovf_d       = 1'b0;
        end
      endcase
    end

    // Registered status outputs follow the next state so they stay glitch-free.
    in_ready_d = (state_d == ACCUM);
    busy_d     = (cnt_d != {CNT_W{1'b0}});
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_acc_q   <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_acc_q   <= out_acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_approx_dot_accumulator.sv
// Directed testbench for approx_dot_accumulator. Three instances with
// different LEN/ACC_W share the same stimulus; each step checks only the
// instance whose configuration the step targets.
module tb_approx_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_z;

  // LEN=4, ACC_W=18
  logic        a_in_ready, a_out_valid, a_ovf, a_busy;
  logic [17:0] a_out_acc;
  // defaults LEN=8, ACC_W=19
  logic        d_in_ready, d_out_valid, d_ovf, d_busy;
  logic [18:0] d_out_acc;
  // LEN=2, ACC_W=16
  logic        s_in_ready, s_out_valid, s_ovf, s_busy;
  logic [15:0] s_out_acc;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  approx_dot_accumulator #(.LEN(4), .ACC_W(18)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_z(in_z), .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc),
    .ovf(a_ovf), .busy(a_busy)
  );

  approx_dot_accumulator u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_z(in_z), .out_valid(d_out_valid), .out_ready(out_ready), .out_acc(d_out_acc),
    .ovf(d_ovf), .busy(d_busy)
  );

  approx_dot_accumulator #(.LEN(2), .ACC_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_z(in_z), .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
    .ovf(s_ovf), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] z);
    in_valid = 1'b1;
    in_z     = z;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_z     = 16'd0;
    tick();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    clr       = 1'b0;
    in_z      = 16'd0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_in_ready"},  {31'd0, a_in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'd0, a_out_valid}, 32'd0);
    chk({tag, "_out_acc"},   {14'd0, a_out_acc},   32'd0);
    chk({tag, "_ovf"},       {31'd0, a_ovf},       32'd0);
    chk({tag, "_busy"},      {31'd0, a_busy},      32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_z      = 16'd0;

    // ---- reset values ----
    do_reset();
    chk_a_reset("rst");

    // ---- basic LEN=4 sum: 100+200+300+400 ----
    out_ready = 1'b1;
    beat(16'd100);
    chk("basic_busy1", {31'd0, a_busy}, 32'd1);
    beat(16'd200);
    beat(16'd300);
    chk("basic_valid_early", {31'd0, a_out_valid}, 32'd0);
    beat(16'd400);
    chk("basic_valid", {31'd0, a_out_valid}, 32'd1);
    chk("basic_acc", {14'd0, a_out_acc}, 32'd1000);
    chk("basic_ovf", {31'd0, a_ovf}, 32'd0);
    chk("basic_in_ready_hold", {31'd0, a_in_ready}, 32'd0);
    chk("basic_busy_hold", {31'd0, a_busy}, 32'd0);
    idle();
    chk("basic_valid_drop", {31'd0, a_out_valid}, 32'd0);
    chk("basic_in_ready_back", {31'd0, a_in_ready}, 32'd1);

    // ---- defaults: 8 x 65025 = 520200 ----
    do_reset();
    for (int i = 0; i < 8; i++) beat(16'd65025);
    chk("def_valid", {31'd0, d_out_valid}, 32'd1);
    chk("def_acc", {13'd0, d_out_acc}, 32'd520200);
    chk("def_ovf", {31'd0, d_ovf}, 32'd0);
    idle();

    // ---- LEN=2, ACC_W=16 overflow: 130050 mod 65536 = 64514 ----
    do_reset();
    out_ready = 1'b0;
    beat(16'd65025);
    chk("ovf_no_carry_yet", {31'd0, s_ovf}, 32'd0);
    beat(16'd65025);
    chk("ovf_valid", {31'd0, s_out_valid}, 32'd1);
    chk("ovf_acc", {16'd0, s_out_acc}, 32'd64514);
    chk("ovf_flag", {31'd0, s_ovf}, 32'd1);
    in_valid  = 1'b0;
    tick();
    chk("ovf_flag_held", {31'd0, s_ovf}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("ovf_valid_drop", {31'd0, s_out_valid}, 32'd0);
    chk("ovf_clear", {31'd0, s_ovf}, 32'd0);

    // ---- backpressure on LEN=4: 10+20+30+40 held for 5 cycles ----
    do_reset();
    out_ready = 1'b0;
    beat(16'd10);
    beat(16'd20);
    beat(16'd30);
    beat(16'd40);
    for (int i = 0; i < 5; i++) begin
      beat(16'd999);
      chk("bp_valid", {31'd0, a_out_valid}, 32'd1);
      chk("bp_acc", {14'd0, a_out_acc}, 32'd100);
      chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    beat(16'd999);
    chk("bp_transfer", {31'd0, a_out_valid}, 32'd0);
    chk("bp_busy_after", {31'd0, a_busy}, 32'd0);
    beat(16'd1);
    beat(16'd1);
    beat(16'd1);
    beat(16'd1);
    chk("bp_next_valid", {31'd0, a_out_valid}, 32'd1);
    chk("bp_next_acc", {14'd0, a_out_acc}, 32'd4);
    idle();

    // ---- bubbles: 5,-,-,6,-,7,8 -> 26 ----
    do_reset();
    beat(16'd5);
    in_valid = 1'b0; in_z = 16'd999; tick();
    in_valid = 1'b0; in_z = 16'd500; tick();
    chk("bub_busy", {31'd0, a_busy}, 32'd1);
    beat(16'd6);
    in_valid = 1'b0; in_z = 16'd777; tick();
    beat(16'd7);
    chk("bub_valid_early", {31'd0, a_out_valid}, 32'd0);
    beat(16'd8);
    chk("bub_valid", {31'd0, a_out_valid}, 32'd1);
    chk("bub_acc", {14'd0, a_out_acc}, 32'd26);
    idle();

    // ---- clr after 2 beats, then 1+2+3+4 -> 10 ----
    do_reset();
    beat(16'd1000);
    beat(16'd2000);
    clr = 1'b1;
    beat(16'd500);
    clr = 1'b0;
    chk("clr_busy", {31'd0, a_busy}, 32'd0);
    chk("clr_valid", {31'd0, a_out_valid}, 32'd0);
    beat(16'd1);
    beat(16'd2);
    beat(16'd3);
    beat(16'd4);
    chk("clr_acc", {14'd0, a_out_acc}, 32'd10);
    chk("clr_sum_valid", {31'd0, a_out_valid}, 32'd1);
    // clr while a result is pending drops it
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    chk("clr_hold_valid", {31'd0, a_out_valid}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hold_drop", {31'd0, a_out_valid}, 32'd0);
    chk("clr_hold_ready", {31'd0, a_in_ready}, 32'd1);

    // ---- asynchronous reset mid-sum and in HOLD ----
    do_reset();
    out_ready = 1'b0;
    beat(16'd3);
    beat(16'd3);
    chk("arst_busy_pre", {31'd0, a_busy}, 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_a_reset("arst_mid");
    #1;
    rst_n = 1'b1;
    tick();
    beat(16'd3);
    beat(16'd3);
    beat(16'd3);
    beat(16'd3);
    chk("arst_hold_valid", {31'd0, a_out_valid}, 32'd1);
    chk("arst_hold_acc", {14'd0, a_out_acc}, 32'd12);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_a_reset("arst_hold");
    #1;
    rst_n = 1'b1;
    tick();
    beat(16'd3);
    beat(16'd3);
    beat(16'd3);
    beat(16'd3);
    chk("arst_after_valid", {31'd0, a_out_valid}, 32'd1);
    chk("arst_after_acc", {14'd0, a_out_acc}, 32'd12);
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
